mul_div_unit: RTL and testbench

Iterative multiply/divide unit extending the single-cycle ALU with MIPS MULT/MULTU/DIV/DIVU semantics. It is parametrised in operand width and produces a double-width HI/LO result over multiple cycles under a start/busy/done handshake. It sits beside the ALU in the execute stage. The pipeline stalls on `busy` and reads HI/LO via MFHI/MFLO after `done`.

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_sign_fix.sv | 13 +
 rtl/mul_div_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// operation encodings, FSM state encodings and small decode helpers.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Divide operations have op[1] set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed operations have op[0] clear.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// sign_fix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to apply result signs.
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO result.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle, then a FIX cycle that applies signs and writes hi/lo.
// Optional build macro: MULDIV_EARLY_OUT_EN -- multiplies stop as soon as
// the remaining multiplier bits are all zero (minimum one step).
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: running product. Divide: {remainder, quotient/dividend}.
  // Divide by zero: {raw dividend, all ones} passed straight through.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiply: shifted multiplicand magnitude. Divide: divisor magnitude.
  logic [2*WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 is_div_q, is_div_d;
  logic                 dbz_q, dbz_d;
  // Holds FIX for one extra cycle on divide by zero (two-cycle latency).
  logic                 fix_hold_q, fix_hold_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_by_zero_q, div_by_zero_d;

  logic                 op_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed, rem_fixed;
  logic [WIDTH:0]       div_trial, div_diff;
  logic [2*WIDTH-1:0]   div_acc_next, mul_acc_next;
  logic                 mul_last;

  assign op_signed = md_is_signed(op);

  sign_fix #(.W(WIDTH)) u_mag_a (
    .val_i (inA),
    .neg_i (op_signed & inA[WIDTH-1]),
    .val_o (mag_a)
  );

  sign_fix #(.W(WIDTH)) u_mag_b (
    .val_i (inB),
    .neg_i (op_signed & inB[WIDTH-1]),
    .val_o (mag_b)
  );

  sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .val_i (acc_q),
    .neg_i (neg_res_q),
    .val_o (prod_fixed)
  );

  sign_fix #(.W(WIDTH)) u_quo_fix (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (neg_res_q),
    .val_o (quo_fixed)
  );

  sign_fix #(.W(WIDTH)) u_rem_fix (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (neg_rem_q),
    .val_o (rem_fixed)
  );

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits (no borrow out of bit WIDTH).
  assign div_trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff     = div_trial - {1'b0, opa_q[WIDTH-1:0]};
  assign div_acc_next = div_diff[WIDTH]
                      ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                      : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Shift-add multiply step on the current multiplier LSB.
  assign mul_acc_next = acc_q + (mplier_q[0] ? opa_q : '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == CNT_LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt_q == CNT_LAST);
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and datapath updates.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    opa_d         = opa_q;
    mplier_d      = mplier_q;
    is_div_d      = is_div_q;
    dbz_d         = dbz_q;
    fix_hold_d    = fix_hold_q;
    neg_res_d     = neg_res_q;
    neg_rem_d     = neg_rem_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d      = md_is_div(op);
          dbz_d         = md_is_div(op) && (inB == '0);
          neg_res_d     = op_signed & (inA[WIDTH-1] ^ inB[WIDTH-1]);
          neg_rem_d     = op_signed & inA[WIDTH-1];
          div_by_zero_d = 1'b0;
          cnt_d         = '0;
          fix_hold_d    = 1'b0;
          if (md_is_div(op) && (inB == '0)) begin
            acc_d      = {inA, {WIDTH{1'b1}}};
            fix_hold_d = 1'b1;
            state_d    = FIX;
          end else if (md_is_div(op)) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opa_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = RUN;
          end else begin
            acc_d    = '0;
            opa_d    = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_d = div_acc_next;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end else begin
          acc_d    = mul_acc_next;
          opa_d    = opa_q << 1;
          mplier_d = mplier_q >> 1;
          if (mul_last) state_d = FIX;
        end
      end

      FIX: begin
        if (fix_hold_q) begin
          fix_hold_d = 1'b0;
        end else begin
          if (dbz_q) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end else if (is_div_q) begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end else begin
            hi_d = prod_fixed[2*WIDTH-1:WIDTH];
            lo_d = prod_fixed[WIDTH-1:0];
          end
          done_d        = 1'b1;
          div_by_zero_d = dbz_q;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; reset discards any in-flight result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      opa_q         <= '0;
      mplier_q      <= '0;
      is_div_q      <= 1'b0;
      dbz_q         <= 1'b0;
      fix_hold_q    <= 1'b0;
      neg_res_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      opa_q         <= opa_d;
      mplier_q      <= mplier_d;
      is_div_q      <= is_div_d;
      dbz_q         <= dbz_d;
      fix_hold_q    <= fix_hold_d;
      neg_res_q     <= neg_res_d;
      neg_rem_q     <= neg_rem_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (WIDTH=32). Honours MULDIV_EARLY_OUT_EN
// when computing expected multiply latencies.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .inA         (inA),
    .inB         (inB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected cycles from accepting edge to the done edge for a multiply.
  function automatic int exp_mul_lat(input logic [31:0] mag);
`ifdef MULDIV_EARLY_OUT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  // Issue one operation (caller is #1 after an edge), wait for done, check all.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz);
    int lat;
    logic busy_ok;
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); inA = $urandom; inB = $urandom;
    check_eq({tag, ".busy_acc"}, {63'd0, busy}, 64'd1);
    check_eq({tag, ".dbz_clr"}, {63'd0, div_by_zero}, 64'd0);
    check_eq({tag, ".hold"}, {hi, lo}, {prev_hi, prev_lo});
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".busy_mid"}, {63'd0, busy_ok}, 64'd1);
    check_eq({tag, ".busy_end"}, {63'd0, busy}, 64'd0);
    check_eq({tag, ".hilo"}, {hi, lo}, {exp_hi, exp_lo});
    check_eq({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    $display("%s op=%0d a=%h b=%h lat=%0d hi=%h lo=%h dbz=%0b", tag, o, a, b, lat, hi, lo, div_by_zero);
    @(posedge clock); #1;
    check_eq({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int lat;
    // Reset state.
    #1;
    check_eq("rst.outs", {busy, done, div_by_zero, hi, lo}, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    run_op("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, exp_mul_lat(32'd7),
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by_zero", MD_DIV, 32'h1234_5678, 32'd0, 2, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("div_after_dbz", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_mul_lat(32'hFFFF_FFFF),
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_negneg", MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, exp_mul_lat(32'd3),
           32'h0, 32'd6, 1'b0);
    run_op("div_rem_sign", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);

    // Start while busy is ignored.
    start = 1'b1; op = MD_MULTU; inA = 32'h10; inB = 32'hF000_0000;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 5) begin
        start = 1'b1; op = MD_DIV; inA = 32'd5; inB = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("busy_start.latency", 64'(lat), 64'd33);
    check_eq("busy_start.hilo", {hi, lo}, {32'hF, 32'h0});
    check_eq("busy_start.dbz", {63'd0, div_by_zero}, 64'd0);
    $display("busy_start lat=%0d hi=%h lo=%h dbz=%0b", lat, hi, lo, div_by_zero);
    @(posedge clock); #1;
    check_eq("busy_start.idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation.
    start = 1'b1; op = MD_MULTU; inA = 32'd7; inB = 32'hF000_0009;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check_eq("mid_reset.outs", {busy, done, div_by_zero, hi, lo}, '0);
    $display("mid_reset busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
    @(posedge clock); #1;
    reset = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    @(posedge clock); #1;
    run_op("after_reset", MD_MULT, 32'hFFFF_FFFD, 32'd7, exp_mul_lat(32'd7),
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

`ifdef MULDIV_EARLY_OUT_EN
    run_op("eo_multu_3x5", MD_MULTU, 32'd3, 32'd5, 4, 32'd0, 32'd15, 1'b0);
    run_op("eo_mult_9x0", MD_MULT, 32'd9, 32'd0, 2, 32'd0, 32'd0, 1'b0);
    run_op("eo_divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
